// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake bundle: MEM stage fields, data-memory read return,
// the upstream stall and the register-file write port.
interface wb_stage_if;
  logic        valid_mem;
  logic        RegWrite_mem;
  logic [1:0]  MemtoReg_mem;
  logic [4:0]  RegWriteAddr_mem;
  logic [31:0] ALUResult_mem;
  logic [31:0] PC8_mem;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        stall_wb;
  logic        RegWrite_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] RegWriteData_wb;

  modport master (
    output valid_mem, RegWrite_mem, MemtoReg_mem, RegWriteAddr_mem,
           ALUResult_mem, PC8_mem, rdata_valid, rdata,
    input  stall_wb, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb
  );

  modport slave (
    input  valid_mem, RegWrite_mem, MemtoReg_mem, RegWriteAddr_mem,
           ALUResult_mem, PC8_mem, rdata_valid, rdata,
    output stall_wb, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, write-back source select and a
// bounded stall while a load waits for late data-memory read data.
module wb_stage #(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   bus,
  output logic [31:0] retired_count,
  output logic        load_err
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(LOAD_TIMEOUT);

  typedef enum logic {RUN, WAIT} state_t;

  state_t      state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic        wb_valid;
  logic        wb_regwrite;
  logic [1:0]  wb_memtoreg;
  logic [4:0]  wb_addr;
  logic [31:0] wb_alu;
  logic [31:0] wb_pc8;

  logic        is_load;
  logic        stall;
  logic        ready;
  logic        timeout;
  logic [31:0] wdata;

  assign is_load = wb_valid && (wb_memtoreg == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      cnt           <= '0;
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= 2'b00;
      wb_addr       <= 5'd0;
      wb_alu        <= 32'd0;
      wb_pc8        <= 32'd0;
      retired_count <= 32'd0;
      load_err      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (!stall) begin
        wb_valid    <= bus.valid_mem;
        wb_regwrite <= bus.RegWrite_mem;
        wb_memtoreg <= bus.MemtoReg_mem;
        wb_addr     <= bus.RegWriteAddr_mem;
        wb_alu      <= bus.ALUResult_mem;
        wb_pc8      <= bus.PC8_mem;
      end
      // A timed-out load still retires; it just never writes.
      if (wb_valid && !stall)
        retired_count <= retired_count + 32'd1;
      if (timeout)
        load_err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    ready      = 1'b1;
    timeout    = 1'b0;
    case (state)
      RUN: begin
        if (is_load && !bus.rdata_valid) begin
          stall      = 1'b1;
          ready      = 1'b0;
          state_next = WAIT;
          cnt_next   = CW'(1);
        end
      end
      WAIT: begin
        // Data arriving on the final permitted cycle beats the timeout.
        if (bus.rdata_valid) begin
          state_next = RUN;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT) begin
          ready      = 1'b0;
          timeout    = 1'b1;
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          stall    = 1'b1;
          ready    = 1'b0;
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    case (wb_memtoreg)
      2'b01:   wdata = bus.rdata;
      2'b10:   wdata = wb_pc8;
      default: wdata = wb_alu;
    endcase
  end

  // Outputs are forced quiet while reset is held, even mid-wait.
  assign bus.stall_wb        = stall && !reset;
  assign bus.RegWrite_wb     = wb_valid && wb_regwrite && (wb_addr != 5'd0) && ready && !reset;
  assign bus.RegWriteAddr_wb = reset ? 5'd0 : wb_addr;
  assign bus.RegWriteData_wb = reset ? 32'd0 : wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with LOAD_TIMEOUT=4: ALU/jal/$0 writes, late load,
// data on the timeout cycle, load timeout, reset mid-wait and counter wrap.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic [31:0] retired_count;
  logic        load_err;
  int          checks;
  int          errors;

  wb_stage_if bus ();

  wb_stage #(.LOAD_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .retired_count (retired_count),
    .load_err      (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkWb(input string tag, input logic stall, input logic we,
                         input logic [4:0] addr, input logic [31:0] data);
    checkOutput({tag, ".stall"}, {31'd0, bus.stall_wb}, {31'd0, stall});
    checkOutput({tag, ".we"},    {31'd0, bus.RegWrite_wb}, {31'd0, we});
    checkOutput({tag, ".addr"},  {27'd0, bus.RegWriteAddr_wb}, {27'd0, addr});
    checkOutput({tag, ".data"},  bus.RegWriteData_wb, data);
  endtask

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] mtr,
                               input logic [4:0] addr, input logic [31:0] alu,
                               input logic [31:0] pc8, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    bus.valid_mem        = v;
    bus.RegWrite_mem     = rw;
    bus.MemtoReg_mem     = mtr;
    bus.RegWriteAddr_mem = addr;
    bus.ALUResult_mem    = alu;
    bus.PC8_mem          = pc8;
    bus.rdata_valid      = rv;
    bus.rdata            = rd;
    #1;
  endtask

  task automatic bubble(input logic rv, input logic [31:0] rd);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, rv, rd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;

    bubble(1'b0, 32'd0);
    checkWb("reset", 1'b0, 1'b0, 5'd0, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd8, 32'h1234_5678, 32'd0, 1'b0, 32'd0);
    checkWb("empty", 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("cnt_reset", retired_count, 32'd0);
    checkOutput("err_reset", {31'd0, load_err}, 32'd0);

    applyStimulus(1'b1, 1'b1, 2'b10, 5'd31, 32'hDEAD_BEEF, 32'h0040_0010, 1'b0, 32'd0);
    checkWb("alu", 1'b0, 1'b1, 5'd8, 32'h1234_5678);
    checkOutput("cnt_alu_pre", retired_count, 32'd0);

    applyStimulus(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_0055, 32'd0, 1'b0, 32'd0);
    checkWb("jal", 1'b0, 1'b1, 5'd31, 32'h0040_0010);
    checkOutput("cnt_alu", retired_count, 32'd1);

    applyStimulus(1'b1, 1'b1, 2'b01, 5'd9, 32'h0000_1111, 32'd0, 1'b0, 32'd0);
    checkWb("zero", 1'b0, 1'b0, 5'd0, 32'h0000_0055);
    checkOutput("cnt_jal", retired_count, 32'd2);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 5'd10, 32'hA0A0_A0A0, 32'd0, 1'b0, 32'd0);
      checkWb($sformatf("late_stall%0d", i), 1'b1, 1'b0, 5'd9, 32'd0);
      checkOutput($sformatf("late_cnt%0d", i), retired_count, 32'd3);
    end
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd10, 32'hA0A0_A0A0, 32'd0, 1'b1, 32'hCAFE_BABE);
    checkWb("late_write", 1'b0, 1'b1, 5'd9, 32'hCAFE_BABE);

    bubble(1'b0, 32'd0);
    checkWb("after_late", 1'b0, 1'b1, 5'd10, 32'hA0A0_A0A0);
    checkOutput("cnt_late", retired_count, 32'd4);

    applyStimulus(1'b1, 1'b1, 2'b01, 5'd15, 32'd0, 32'd0, 1'b0, 32'd0);
    checkWb("bubble", 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("cnt_bubble", retired_count, 32'd5);

    for (int i = 0; i < 4; i++) begin
      bubble(1'b0, 32'd0);
      checkWb($sformatf("edge_stall%0d", i), 1'b1, 1'b0, 5'd15, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd12, 32'd0, 32'd0, 1'b1, 32'h0000_0044);
    checkWb("edge_write", 1'b0, 1'b1, 5'd15, 32'h0000_0044);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 5'd13, 32'h0000_0013, 32'd0, 1'b0, 32'd0);
      checkWb($sformatf("to_stall%0d", i), 1'b1, 1'b0, 5'd12, 32'd0);
      checkOutput($sformatf("to_err%0d", i), {31'd0, load_err}, 32'd0);
    end
    checkOutput("cnt_edge", retired_count, 32'd6);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd13, 32'h0000_0013, 32'd0, 1'b0, 32'd0);
    checkWb("to_release", 1'b0, 1'b0, 5'd12, 32'd0);

    applyStimulus(1'b1, 1'b1, 2'b01, 5'd14, 32'd0, 32'd0, 1'b1, 32'hFFFF_0000);
    checkWb("rv_ignored", 1'b0, 1'b1, 5'd13, 32'h0000_0013);
    checkOutput("err_set", {31'd0, load_err}, 32'd1);
    checkOutput("cnt_timeout", retired_count, 32'd7);

    applyStimulus(1'b1, 1'b1, 2'b01, 5'd17, 32'd0, 32'd0, 1'b1, 32'h0BAD_F00D);
    checkWb("ld_imm", 1'b0, 1'b1, 5'd14, 32'h0BAD_F00D);
    checkOutput("err_sticky", {31'd0, load_err}, 32'd1);
    checkOutput("cnt_ign", retired_count, 32'd8);

    bubble(1'b0, 32'd0);
    checkWb("mid_stall", 1'b1, 1'b0, 5'd17, 32'd0);
    checkOutput("cnt_imm", retired_count, 32'd9);

    @(negedge clk);
    reset = 1'b1;
    #1;
    checkWb("rst_mid", 1'b0, 1'b0, 5'd0, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd3, 32'h0000_0007, 32'd0, 1'b0, 32'd0);
    checkWb("post_rst", 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("cnt_post_rst", retired_count, 32'd0);
    checkOutput("err_post_rst", {31'd0, load_err}, 32'd0);

    bubble(1'b0, 32'd0);
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    #1;
    checkWb("wrap_op", 1'b0, 1'b1, 5'd3, 32'h0000_0007);
    checkOutput("cnt_preload", retired_count, 32'hFFFF_FFFF);

    bubble(1'b0, 32'd0);
    checkOutput("cnt_wrap", retired_count, 32'd0);
    checkWb("wrap_after", 1'b0, 1'b0, 5'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 5-stage MIPS pipeline; the producer side of the decode-stage register-file write port. It holds the MEM/WB pipeline register and selects the write-back source: ALU result, load data or link address. It drives the write port for exactly one cycle per retiring instruction. It stalls upstream while a load waits for late data-memory read data, and bounds that wait with a timeout.

## Interface
Parameters:
- LOAD_TIMEOUT, 15, maximum stall cycles spent waiting for load data (≥1)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- valid_mem  in  1  MEM stage holds a real instruction
- RegWrite_mem  in  1  instruction writes a register
- MemtoReg_mem  in  2  source select: 00 ALU, 01 load data, 10 PC+8 (link), 11 treated as 00
- RegWriteAddr_mem  in  5  destination register
- ALUResult_mem  in  32  ALU result
- PC8_mem  in  32  link address
- rdata_valid  in  1  data-memory read data valid this cycle
- rdata  in  32  data-memory read data
- stall_wb  out  1  WB not accepting; MEM stage and all upstream stages must hold
- RegWrite_wb  out  1  register-file write enable
- RegWriteAddr_wb  out  5  register-file write address
- RegWriteData_wb  out  32  register-file write data
- retired_count  out  32  instructions retired since reset
- load_err  out  1  sticky, a load timed out

## Operation
- MEM/WB register fields: wb_valid, wb_regwrite, wb_memtoreg, wb_addr, wb_alu, wb_pc8.
  - Loaded from the *_mem inputs (wb_valid ← valid_mem) on each edge with stall_wb=0.
  - Held unchanged while stall_wb=1.
- is_load = wb_valid & (wb_memtoreg==01).
- FSM states, with wait counter cnt of width $clog2(LOAD_TIMEOUT+1):
  - RUN, non-load entry: no stall; write if enabled; stay RUN.
  - RUN, is_load with rdata_valid=1: write rdata; no stall; stay RUN.
  - RUN, is_load with rdata_valid=0: stall_wb=1; go to WAIT; cnt←1.
  - WAIT, rdata_valid=1: write rdata; stall_wb=0; go to RUN; cnt←0.
  - WAIT, rdata_valid=0 and cnt==LOAD_TIMEOUT: stall_wb=0; no write; load_err←1; entry retires; go to RUN; cnt←0.
  - WAIT, other cases: stall_wb=1; cnt←cnt+1.
- Write port (combinational from the register, FSM state and rdata):
  - RegWrite_wb = wb_valid & wb_regwrite & (wb_addr≠0) & ready. ready=1 for non-loads and for loads in the cycle rdata_valid=1. It is 0 on the timeout cycle.
  - RegWriteAddr_wb = wb_addr.
  - RegWriteData_wb = rdata if source is 01, wb_pc8 if 10, else wb_alu.
- Destination $0 is never written. The entry still retires.
- retired_count increments by 1 on each edge where wb_valid=1 and stall_wb=0. It wraps 0xFFFFFFFF→0.
- rdata_valid is ignored unless is_load is true.
- The register file commits the write at the end of the cycle in which RegWrite_wb=1.

## Timing
- Reset values: all MEM/WB fields 0, FSM in RUN, cnt=0, retired_count=0, load_err=0.
- Outputs during reset: stall_wb=0, RegWrite_wb=0, RegWriteAddr_wb=0, RegWriteData_wb=0.
- Latency: an instruction in MEM in cycle N drives the write port in cycle N+1 (non-load, or load with rdata_valid in N+1).
- Load data arriving in cycle N+1+k (k≥1): stall_wb=1 in cycles N+1..N+k; write in cycle N+1+k; the next MEM instruction is captured at the end of N+1+k.
- Maximum stall is LOAD_TIMEOUT cycles. The release cycle is N+1+LOAD_TIMEOUT.
- rdata_valid=1 on the same cycle cnt reaches LOAD_TIMEOUT: data wins, the write happens, and load_err is unchanged.
- Back-to-back loads are handled independently; cnt restarts from 0 for each.
- Bubbles (valid_mem=0): no write, no retire, no stall.
- Reset asserted mid-WAIT: the pending load is dropped with no write, and all state returns to reset values on that edge.

## Test plan
- ALU op: valid, RegWrite=1, MemtoReg=00, addr=8, ALU=0x12345678 in cycle 1 -> cycle 2: RegWrite_wb=1, addr 8, data 0x12345678, stall_wb=0; retired_count=1 after the edge.
- jal: MemtoReg=10, addr=31, PC8=0x00400010 -> data 0x00400010 written to 31.
- $0 write: addr=0, RegWrite=1 -> RegWrite_wb=0, retired_count still increments.
- Late load: MemtoReg=01, addr=9, rdata_valid at k=3 with rdata 0xCAFEBABE -> stall_wb=1 for 3 cycles, then a one-cycle write of 0xCAFEBABE to 9; the following ALU op writes in the next cycle.
- Timeout with LOAD_TIMEOUT=4: load, rdata_valid never asserted -> stall_wb=1 for 4 cycles, no write, load_err=1 and stays 1; a subsequent load with rdata_valid immediate writes normally.
- Reset mid-WAIT, plus a wrap check: reset during the 2nd stall cycle -> next cycle stall_wb=0, RegWrite_wb=0, retired_count=0. Run 2^32 retirements via force/preload at 0xFFFFFFFF -> retired_count goes to 0.
